winograd_tile_fetch: RTL

- Upstream feeder for the Winograd convolution core.
- Accepts one image plane per channel as a raster-ordered pixel stream and buffers INPUT_TILE_SIZE rows.
- Emits overlapping INPUT_TILE_SIZE×INPUT_TILE_SIZE input tiles with stride INPUT_TILE_SIZE−KERNEL_SIZE+1, one tile per handshake, in the packed form the core consumes.

---
 rtl/winograd_pkg.sv | 29 ++
 rtl/winograd_row_buffer.sv | 49 ++++
 rtl/winograd_tile_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// Shared constants, state encoding and tile packing for the Winograd input path.
// Packing helper is also used by the convolution core to unpack tiles.
package winograd_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } fetch_state_t;

    function automatic int stride_of(input int t, input int k);
        return t - k + 1;
    endfunction

    function automatic int tpd_of(input int w, input int t, input int k);
        return (w - t) / stride_of(t, k) + 1;
    endfunction

    // LSB of tile element (row i, column j) in the packed T*T*D tile word.
    function automatic int elem_lsb(input int i, input int j, input int t, input int d);
        return (i * t + j) * d;
    endfunction

    localparam int WG_KERNEL_SIZE = 3;
    localparam int WG_TILE_SIZE   = 4;
    localparam int WG_IMAGE_WIDTH = 10;
    localparam int WG_STRIDE      = stride_of(WG_TILE_SIZE, WG_KERNEL_SIZE);
    localparam int WG_TPD         = tpd_of(WG_IMAGE_WIDTH, WG_TILE_SIZE, WG_KERNEL_SIZE);

endpackage

// File: rtl/winograd_row_buffer.sv
// T circular row slots of W pixels with one write port and a combinational TxT window read.
// The read bypasses a same-cycle write so a tile can be captured on the edge that completes it.
module winograd_row_buffer
    import winograd_pkg::*;
#(
    parameter int T      = 4,
    parameter int W      = 10,
    parameter int D      = 8,
    parameter int SLOT_W = 2,
    parameter int COL_W  = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [D-1:0]      wr_data,
    input  logic [SLOT_W-1:0] rd_base,
    input  logic [COL_W-1:0]  rd_col,
    output logic [T*T*D-1:0]  window
);

    logic [D-1:0]      mem [T][W];
    logic [SLOT_W-1:0] rs;
    logic [COL_W-1:0]  rc;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    always_comb begin
        window = '0;
        rs     = '0;
        rc     = '0;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                rs = SLOT_W'((int'(rd_base) + i) % T);
                rc = COL_W'(int'(rd_col) + j);
                if (wr_en && (rs == wr_slot) && (rc == wr_col)) begin
                    window[elem_lsb(i, j, T, D) +: D] = wr_data;
                end else begin
                    window[elem_lsb(i, j, T, D) +: D] = mem[rs][rc];
                end
            end
        end
    end

endmodule

// File: rtl/winograd_tile_fetch.sv
// Buffers raster pixel rows and streams overlapping TxT tiles to the Winograd core.
// Define WINOGRAD_TILE_COORD_EN to expose tile_row / tile_col / tile_chan ports.
//
// state | meaning
// FILL  | accepting pixels until the rows needed for the next tile row are buffered
// EMIT  | presenting registered tiles of one tile row, one per handshake
module winograd_tile_fetch
    import winograd_pkg::*;
#(
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_IMAGE_WIDTH = 10,
    parameter int INPUT_TILE_SIZE   = 4,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int CHANNELS          = 3,
    localparam int TPD = tpd_of(INPUT_IMAGE_WIDTH, INPUT_TILE_SIZE, KERNEL_SIZE),
    localparam int CW  = (TPD > 1) ? $clog2(TPD) : 1,
    localparam int HW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]                           in_pixel,
    output logic                                                  tile_valid,
    input  logic                                                  tile_ready,
    output logic                                                  tile_last,
`ifdef WINOGRAD_TILE_COORD_EN
    output logic [CW-1:0]                                         tile_row,
    output logic [CW-1:0]                                         tile_col,
    output logic [HW-1:0]                                         tile_chan,
`endif
    output logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH-1:0] tile_data
);

    localparam int T    = INPUT_TILE_SIZE;
    localparam int W    = INPUT_IMAGE_WIDTH;
    localparam int D    = INPUT_DATA_WIDTH;
    localparam int S    = stride_of(T, KERNEL_SIZE);
    localparam int SW   = (T > 1) ? $clog2(T) : 1;
    localparam int COLW = (W > 1) ? $clog2(W) : 1;
    localparam int RW   = $clog2(T + 1);

    fetch_state_t      state_q, state_d;
    logic [COLW-1:0]   col_q;
    logic [RW-1:0]     rows_q;
    logic [SW-1:0]     wr_slot_q, base_q;
    logic [CW-1:0]     trow_q, tcol_q;
    logic [HW-1:0]     chan_q;
    logic [T*T*D-1:0]  tile_q, window;
    logic [COLW-1:0]   rd_col;
    logic [RW-1:0]     need_m1;
    logic              accept, hs, row_end, fill_done, col_end, row_done, plane_done, load_tile;

    assign accept     = in_valid && in_ready;
    assign hs         = tile_valid && tile_ready;
    assign row_end    = accept && (col_q == COLW'(W - 1));
    assign need_m1    = (trow_q == '0) ? RW'(T - 1) : RW'(S - 1);
    assign fill_done  = row_end && (rows_q == need_m1);
    assign col_end    = (tcol_q == CW'(TPD - 1));
    assign row_done   = hs && col_end;
    assign plane_done = row_done && (trow_q == CW'(TPD - 1));
    assign load_tile  = fill_done || (hs && !col_end);

    // FILL reads tile column 0 of the new tile row; EMIT pre-reads the next tile column.
    assign rd_col = (state_q == ST_EMIT && !col_end) ? COLW'((int'(tcol_q) + 1) * S) : '0;

    winograd_row_buffer #(
        .T      (T),
        .W      (W),
        .D      (D),
        .SLOT_W (SW),
        .COL_W  (COLW)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_slot (wr_slot_q),
        .wr_col  (col_q),
        .wr_data (in_pixel),
        .rd_base (base_q),
        .rd_col  (rd_col),
        .window  (window)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (fill_done) state_d = ST_EMIT;
            ST_EMIT: if (row_done)  state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_FILL);
        tile_valid = (state_q == ST_EMIT);
        tile_last  = (trow_q == CW'(TPD - 1)) && col_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= '0;
            rows_q    <= '0;
            wr_slot_q <= '0;
            base_q    <= '0;
            trow_q    <= '0;
            tcol_q    <= '0;
            chan_q    <= '0;
            tile_q    <= '0;
        end else begin
            if (accept) begin
                if (row_end) begin
                    col_q     <= '0;
                    rows_q    <= rows_q + 1'b1;
                    wr_slot_q <= SW'((int'(wr_slot_q) + 1) % T);
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (load_tile) begin
                tile_q <= window;
            end
            if (hs) begin
                if (col_end) begin
                    tcol_q <= '0;
                    rows_q <= '0;
                    if (plane_done) begin
                        trow_q    <= '0;
                        base_q    <= '0;
                        wr_slot_q <= '0;
                        col_q     <= '0;
                        chan_q    <= (chan_q == HW'(CHANNELS - 1)) ? '0 : chan_q + 1'b1;
                    end else begin
                        trow_q <= trow_q + 1'b1;
                        base_q <= SW'((int'(base_q) + S) % T);
                    end
                end else begin
                    tcol_q <= tcol_q + 1'b1;
                end
            end
        end
    end

    assign tile_data = tile_q;

`ifdef WINOGRAD_TILE_COORD_EN
    assign tile_row  = trow_q;
    assign tile_col  = tcol_q;
    assign tile_chan = chan_q;
`endif

endmodule
